// File: rtl/disp_scan_if.sv
// Bundle of value-source / scan-output signals between a display value source
// and the display scan controller.
interface disp_scan_if;
    logic        en;          // scan enable; low = display dark, counters frozen
    logic [15:0] value;       // four packed BCD digits, [3:0] is rightmost
    logic        load;        // request to capture value
    logic        ready;       // update buffer empty, load will be accepted
    logic        lz_en;       // leading-zero suppression enable
    logic [3:0]  bcd;         // digit code to the seven-segment decoder
    logic        blank;       // decoder must turn all segments off
    logic [3:0]  an;          // anodes, active-low, at most one low
    logic [1:0]  digit;       // index of the digit currently in its slot
    logic        frame_tick;  // one-cycle pulse at each frame boundary

    // Value source / bench side
    modport master (
        output en, value, load, lz_en,
        input  ready, bcd, blank, an, digit, frame_tick
    );

    // Scan controller side
    modport slave (
        input  en, value, load, lz_en,
        output ready, bcd, blank, an, digit, frame_tick
    );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Four-digit display scan controller. Steps one shared BCD decoder across the
// four anodes, with an all-off dead time at the start of every digit slot,
// optional leading-zero blanking, and a one-entry update buffer that is only
// copied into the displayed frame at a frame boundary so digits never tear.
//
// All display outputs are registers loaded from the next-state counter and
// frame values, so in any cycle they line up with the slot_cnt/digit held in
// that same cycle, while never depending combinationally on an input.
module disp_scan_ctrl #(
    parameter int SLOT = 50000,   // cycles per digit slot, must be >= DEAD+2
    parameter int DEAD = 500      // leading all-off cycles per slot, >= 1
) (
    input  logic         clk,
    input  logic         rst,     // asynchronous, active-low
    disp_scan_if.slave   scan
);

    localparam int CW = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT - 1);
    localparam logic [CW-1:0] DEAD_END  = CW'(DEAD);

    // Slot phase: all anodes off first, then the selected digit lit.
    typedef enum logic {
        PH_DEAD = 1'b0,
        PH_ON   = 1'b1
    } phase_t;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [CW-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]    digit_q,    digit_d;
    logic [15:0]   disp_q,     disp_d;
    logic [15:0]   pend_q,     pend_d;
    logic          pend_v_q,   pend_v_d;

    // Registered outputs
    logic [3:0]    an_q,         an_d;
    logic [3:0]    bcd_q,        bcd_d;
    logic          blank_q,      blank_d;
    logic          frame_tick_q, frame_tick_d;

    // Helpers for the output decode of the upcoming cycle
    phase_t        phase_d;
    logic [3:0]    nib_sel;
    logic [3:0]    nib_zero;      // nibble gi of the next frame is zero
    logic [3:0]    upper_zero;    // nibbles gi..3 of the next frame are all zero
    logic          lz_hit;

    // ------------------------------------------------------------------
    // Zero detection per nibble and for every "from this digit upward" span
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_zero
            assign nib_zero[gi]   = (disp_d[4*gi +: 4] == 4'd0);
            assign upper_zero[gi] = &nib_zero[3:gi];
        end
    endgenerate

    // Next-state for counters, displayed frame and the update buffer.
    always_comb begin
        slot_cnt_d = slot_cnt_q;
        digit_d    = digit_q;
        disp_d     = disp_q;
        pend_d     = pend_q;
        pend_v_d   = pend_v_q;

        if (scan.en) begin
            if (slot_cnt_q == SLOT_LAST) begin
                slot_cnt_d = '0;
                digit_d    = digit_q + 2'd1;
                // Frame boundary: promote the buffered value, if any.
                if (digit_q == 2'd3 && pend_v_q) begin
                    disp_d   = pend_q;
                    pend_v_d = 1'b0;
                end
            end else begin
                slot_cnt_d = slot_cnt_q + CW'(1);
            end
        end

        // Buffer accepts only while empty. A transfer and an accepted load
        // can never coincide: transfer needs pend_v_q=1, acceptance needs 0.
        if (scan.load && !pend_v_q) begin
            pend_d   = scan.value;
            pend_v_d = 1'b1;
        end
    end

    // Output decode for the cycle the next-state counters describe.
    always_comb begin
        phase_d = (slot_cnt_d >= DEAD_END) ? PH_ON : PH_DEAD;
        nib_sel = disp_d[{digit_d, 2'b00} +: 4];
        lz_hit  = scan.lz_en && (digit_d != 2'd0) && upper_zero[digit_d];

        if (scan.en && phase_d == PH_ON) begin
            an_d = ~(4'b0001 << digit_d);
        end else begin
            an_d = 4'b1111;
        end

        bcd_d        = nib_sel;
        blank_d      = !scan.en || (phase_d == PH_DEAD) || (nib_sel > 4'd9) || lz_hit;
        frame_tick_d = scan.en && (slot_cnt_d == SLOT_LAST) && (digit_d == 2'd3);
    end

    // All state and output registers; reset drops any pending update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_cnt_q   <= '0;
            digit_q      <= 2'd0;
            disp_q       <= 16'h0000;
            pend_q       <= 16'h0000;
            pend_v_q     <= 1'b0;
            an_q         <= 4'b1111;
            bcd_q        <= 4'd0;
            blank_q      <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            digit_q      <= digit_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            an_q         <= an_d;
            bcd_q        <= bcd_d;
            blank_q      <= blank_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign scan.ready      = ~pend_v_q;
    assign scan.an         = an_q;
    assign scan.bcd        = bcd_q;
    assign scan.blank      = blank_q;
    assign scan.digit      = digit_q;
    assign scan.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with SLOT=8, DEAD=2 (32-cycle frames).
// Cycle n is the interval after the n-th rising edge following reset release;
// inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_disp_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    disp_scan_if scan_if ();

    disp_scan_ctrl #(.SLOT(8), .DEAD(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .scan (scan_if.slave)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          frame_base = 0;
    logic [15:0] exp_disp = 16'h0000;
    logic        exp_ready = 1'b1;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected outputs for the current cycle, from its position in the frame.
    task automatic cycle_check();
        int          p, d, s;
        logic [3:0]  exp_an, nib;
        logic        lzs, exp_blank;
        p   = (cyc - frame_base) % 32;
        d   = p / 8;
        s   = p % 8;
        nib = exp_disp[4*d +: 4];
        lzs = scan_if.lz_en && (d >= 1) && ((exp_disp >> (4*d)) == 16'h0000);
        exp_an    = (s < 2) ? 4'b1111 : ~(4'b0001 << d);
        exp_blank = (s < 2) || (nib > 4'd9) || lzs;
        check("an",    {12'h0, scan_if.an},          {12'h0, exp_an});
        check("digit", {14'h0, scan_if.digit},       16'(d));
        check("bcd",   {12'h0, scan_if.bcd},         {12'h0, nib});
        check("blank", {15'h0, scan_if.blank},       {15'h0, exp_blank});
        check("tick",  {15'h0, scan_if.frame_tick},  {15'h0, (p == 31)});
        check("ready", {15'h0, scan_if.ready},       {15'h0, exp_ready});
    endtask

    task automatic run_to(input int n);
        while (cyc < n) begin
            adv();
            cycle_check();
        end
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_an"},    {12'h0, scan_if.an},         16'h000F);
        check({tag, "_blank"}, {15'h0, scan_if.blank},      16'h0001);
        check({tag, "_ready"}, {15'h0, scan_if.ready},      16'h0001);
        check({tag, "_digit"}, {14'h0, scan_if.digit},      16'h0000);
        check({tag, "_bcd"},   {12'h0, scan_if.bcd},        16'h0000);
        check({tag, "_tick"},  {15'h0, scan_if.frame_tick}, 16'h0000);
    endtask

    task automatic do_load(input logic [15:0] v);
        scan_if.load  = 1'b1;
        scan_if.value = v;
        $display("cyc=%0d load value=%h ready=%0b", cyc, v, scan_if.ready);
    endtask

    initial begin
        scan_if.en    = 1'b1;
        scan_if.load  = 1'b0;
        scan_if.value = 16'h0000;
        scan_if.lz_en = 1'b0;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        reset_values("rst");
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        cycle_check();

        // First load, then a second one while the buffer is full
        run_to(3);
        do_load(16'h1234);
        exp_ready = 1'b0;
        run_to(4);
        scan_if.load = 1'b0;
        run_to(10);
        do_load(16'h5678);
        run_to(11);
        scan_if.load = 1'b0;
        run_to(31);
        exp_disp  = 16'h1234;
        exp_ready = 1'b1;
        run_to(96);

        // Leading-zero suppression: 0070 then 0000
        scan_if.lz_en = 1'b1;
        do_load(16'h0070);
        exp_ready = 1'b0;
        run_to(97);
        scan_if.load = 1'b0;
        run_to(127);
        exp_disp  = 16'h0070;
        exp_ready = 1'b1;
        run_to(130);
        do_load(16'h0000);
        exp_ready = 1'b0;
        run_to(131);
        scan_if.load = 1'b0;
        run_to(159);
        exp_disp  = 16'h0000;
        exp_ready = 1'b1;
        run_to(192);

        // Suppression off, invalid nibble in digit 1
        scan_if.lz_en = 1'b0;
        do_load(16'h00A5);
        exp_ready = 1'b0;
        run_to(193);
        scan_if.load = 1'b0;
        run_to(223);
        exp_disp  = 16'h00A5;
        exp_ready = 1'b1;
        run_to(245);

        // Enable low for 10 cycles from digit 2, slot cycle 5; load while dark
        scan_if.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            adv();
            check("dark_an",    {12'h0, scan_if.an},         16'h000F);
            check("dark_blank", {15'h0, scan_if.blank},      16'h0001);
            check("dark_tick",  {15'h0, scan_if.frame_tick}, 16'h0000);
            check("dark_digit", {14'h0, scan_if.digit},      16'h0002);
            check("dark_ready", {15'h0, scan_if.ready},      {15'h0, exp_ready});
            if (cyc == 247) begin
                do_load(16'h0042);
                exp_ready = 1'b0;
            end
            if (cyc == 248) scan_if.load = 1'b0;
            if (cyc == 255) scan_if.en = 1'b1;
        end
        frame_base = 234;
        run_to(265);
        exp_disp  = 16'h0042;
        exp_ready = 1'b1;
        run_to(280);

        // Mid-frame reset with a value pending
        do_load(16'h0999);
        exp_ready = 1'b0;
        run_to(281);
        scan_if.load = 1'b0;
        run_to(285);
        #2;
        rst = 1'b0;
        #1;
        reset_values("midrst");
        repeat (2) @(posedge clk);
        #1;
        reset_values("midrst_hold");
        @(negedge clk);
        rst = 1'b1;
        cyc        = 0;
        frame_base = 0;
        exp_disp   = 16'h0000;
        exp_ready  = 1'b1;
        cycle_check();
        run_to(64);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Scan controller that time-shares the single BCD-to-seven-segment decoder across the four anodes of the board display. It holds a 16-bit packed BCD frame and steps through the digits at a programmable slot rate, inserting an anode dead-time between digits to suppress ghosting. It also optionally suppresses leading zeros, and accepts new values through a ready/load handshake that applies updates only at frame boundaries, so a value never tears across digits. It sits between the user-facing value source and the existing decoder/anode outputs in `top`, replacing the free-running divider-driven digit select.

## Interface
- `SLOT`, default 50000: clock cycles per digit slot; legal range ≥ `DEAD`+2.
- `DEAD`, default 500: cycles at the start of each slot with all anodes off; legal range ≥ 1.

- `clk`  input  1  system clock.
- `rst`  input  1  asynchronous, active-low reset.
- `en`  input  1  scan enable; low = display dark, counters frozen.
- `value`  input  16  four BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- `load`  input  1  request to capture `value`; honoured only while `ready`=1.
- `ready`  output  1  pending buffer empty, so `load` will be accepted.
- `lz_en`  input  1  leading-zero suppression enable.
- `bcd`  output  4  digit code to the decoder.
- `blank`  output  1  decoder must drive all segments off.
- `an`  output  4  anodes, active-low; at most one bit low.
- `digit`  output  2  index of the digit currently in its slot.
- `frame_tick`  output  1  one-cycle pulse at each frame boundary.

## Operation
- Registers:
  - `slot_cnt` counts 0..`SLOT`-1.
  - `digit` counts 0..3.
  - `disp` (16 bits) holds the displayed frame.
  - `pend` (16 bits) plus `pend_v` form the one-entry update buffer.
- Slot phases are a two-state machine derived from `slot_cnt`:
  - **DEAD** (`slot_cnt` < `DEAD`): `an`=4'b1111.
  - **ON** (`slot_cnt` ≥ `DEAD`): `an` has bit `digit` low and all other bits high.
- Slot advance: when `slot_cnt`=`SLOT`-1, `slot_cnt` goes to 0 and `digit` goes to `digit`+1, wrapping 3→0.
- Frame boundary (`slot_cnt`=`SLOT`-1 with `digit`=3):
  - `frame_tick`=1 for that cycle.
  - If `pend_v`=1: `disp` ← `pend` and `pend_v` ← 0.
- Handshake:
  - `ready` = !`pend_v`.
  - `load`=1 with `ready`=1 captures `value` into `pend` and sets `pend_v`=1 on the next edge.
  - `load` with `ready`=0 is ignored; `pend` is not overwritten.
  - `load` in the same cycle that `pend` transfers into `disp` is ignored, because `ready` is still 0 in that cycle.
- `bcd` = `disp` nibble selected by `digit`.
- `blank`=1 if any of the following holds:
  - the phase is DEAD;
  - `en`=0;
  - the selected nibble is greater than 9 (invalid code; `bcd` still passes the raw nibble);
  - leading-zero suppression applies, i.e. `lz_en`=1 and every nibble from `digit` up to 3 is zero, with `digit` ≥ 1. Digit 0 is never suppressed, so 0000 shows "0".
- `en`=0:
  - `an`=4'b1111 and `blank`=1.
  - `slot_cnt` and `digit` hold their values; the frame boundary does not occur.
  - The handshake still accepts `load`.
  - On the first cycle `en` returns to 1, scanning resumes from the held count.
- Reset (`rst`=0, asynchronous):
  - `slot_cnt`=0, `digit`=0, `disp`=0, `pend`=0, `pend_v`=0.
  - Outputs: `an`=4'b1111, `bcd`=0, `blank`=1, `ready`=1, `frame_tick`=0.
  - Reset asserted mid-slot or mid-frame discards any pending value.

## Timing
- All outputs are registered; `an`, `bcd` and `blank` change only on `clk` rising edges, with no combinational path from inputs.
- Output alignment: outputs reflect the `slot_cnt`/`digit` values registered in the same cycle.
- After `rst` deasserts with `en`=1, `slot_cnt`=0 is the first cycle. Digit 0 anode goes low at cycle `DEAD` and stays low through cycle `SLOT`-1.
- Frame period is 4×`SLOT` cycles.
- Update latency: a load accepted in frame N appears in `disp` at the first slot of frame N+1. Worst case is 4×`SLOT`+1 cycles; best case is 2 cycles (load on the cycle before the boundary).
- `ready` deasserts the cycle after an accepted load and reasserts the cycle after the transfer.

## Test plan
Bench parameters: `SLOT`=8, `DEAD`=2, `en`=1 unless stated.
- **Reset values:** hold `rst`=0 for 3 cycles → `an`=1111, `blank`=1, `ready`=1, `digit`=0. Release → `an`=1110 on cycles 2–7, then `an`=1101 on cycles 10–15; `an`=1111 on cycles 0–1 and 8–9.
- **Handshake and frame update:** load 16'h1234 at cycle 3 → `ready`=0 from cycle 4. `frame_tick` at cycle 31. From cycle 32, `bcd` sequence is 4, 3, 2, 1 for digits 0–3, and `ready`=1.
- **Blocked second load:** load 16'h5678 while `ready`=0 → after the next frame, digits still show 1234.
- **Leading zeros:** `lz_en`=1 with value 16'h0070 → digits 3 and 2 blanked, digit 1 shows `bcd`=7, digit 0 shows `bcd`=0 unblanked. Value 16'h0000 → only digit 0 unblanked. `lz_en`=0 → nothing blanked.
- **Invalid code:** value 16'h00A5 → digit 1 `blank`=1 with `bcd`=A, digit 0 shows 5.
- **Enable and mid-frame reset:**
  - Drop `en` at digit 2, cycle 5 of its slot, for 10 cycles → `an`=1111 throughout, then resume at digit 2, cycle 5.
  - Pulse `rst` low mid-frame with `pend_v`=1 → all reset values, and the pending value is never displayed.
